// File: rtl/cache_ctrl.sv
// -----------------------------------------------------------------------------
// cache_ctrl
// Direct-mapped, write-through / no-write-allocate cache controller sitting
// between a CPU port and a one-word-per-transfer backing memory.
//
// Geometry: 4 lines x 4 words x 32 bits. Each line has a 2-bit tag and a
// valid bit. The word address splits as {tag[5:4], line[3:2], offset[1:0]}.
//
// Ports
//   clk        : single clock, all state updates on the rising edge
//   rst        : synchronous active-low reset
//   cpu_req    : request strobe, accepted only while the controller is idle
//   cpu_we     : 1 = write, 0 = read
//   cpu_addr   : word address
//   cpu_wdata  : write data
//   cpu_ack    : one-cycle completion pulse
//   cpu_hit    : request was served from the cache (only valid with cpu_ack)
//   cpu_rdata  : read data (left unchanged by writes)
//   busy       : controller is not idle
//   mem_req    : memory request, held until a cycle with mem_ack=1
//   mem_we     : memory write
//   mem_addr   : memory word address
//   mem_wdata  : memory write data
//   mem_ack    : memory completion for the current word (ignored if !mem_req)
//   mem_rdata  : memory read data, valid in the mem_ack cycle
// -----------------------------------------------------------------------------
module cache_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [5:0]  cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_ack,
   output logic        cpu_hit,
   output logic [31:0] cpu_rdata,
   output logic        busy,
   output logic        mem_req,
   output logic        mem_we,
   output logic [5:0]  mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REFILL = 2'd1,
      ST_WTHRU  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Controller state
   state_t      r_state;
   logic [3:0]  r_valid;
   logic [1:0]  r_cnt;
   logic [5:0]  r_addr;
   logic        r_we;
   logic        r_hit;

   // Registered outputs
   logic        r_cpu_ack;
   logic        r_cpu_hit;
   logic [31:0] r_cpu_rdata;
   logic        r_mem_req;
   logic        r_mem_we;
   logic [5:0]  r_mem_addr;
   logic [31:0] r_mem_wdata;

   // Storage: data and tags are not reset, only the valid bits are.
   logic [31:0] r_data [16];
   logic [3:0][1:0] w_tag;

   logic [1:0]  w_req_line;
   logic        w_req_hit;
   logic        w_mem_done;
   logic        w_fill_we;
   logic        w_wthru_we;
   logic        w_tag_we;

   assign w_req_line = cpu_addr[3:2];
   assign w_req_hit  = r_valid[w_req_line] && (w_tag[w_req_line] == cpu_addr[5:4]);

   // An ack only counts while a request is actually outstanding.
   assign w_mem_done = r_mem_req && mem_ack;

   // Array writes are suppressed during reset so an aborted transfer
   // cannot land a word in the cache.
   assign w_fill_we  = rst && (r_state == ST_REFILL) && w_mem_done;
   assign w_wthru_we = rst && (r_state == ST_WTHRU) && w_mem_done && r_hit;
   assign w_tag_we   = w_fill_we && (r_cnt == 2'd3);

   // ---------------------------------------------------------------------
   // Data array: refill words arrive in offset order 0..3; a write-through
   // only touches the array when the line was resident at acceptance.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_fill_we) begin
         r_data[{r_addr[3:2], r_cnt}] <= mem_rdata;
      end else if (w_wthru_we) begin
         r_data[r_addr[3:0]] <= r_mem_wdata;
      end
   end

   // ---------------------------------------------------------------------
   // Tag array, one register per line. The tag is written together with
   // the last refill word, at the same edge the valid bit is set.
   // ---------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_tag
         logic [1:0] r_tag_line;
         always_ff @(posedge clk) begin
            if (w_tag_we && (r_addr[3:2] == 2'(gi))) begin
               r_tag_line <= r_addr[5:4];
            end
         end
         assign w_tag[gi] = r_tag_line;
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Main FSM with registered outputs.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_valid     <= 4'b0000;
         r_cnt       <= 2'd0;
         r_addr      <= 6'd0;
         r_we        <= 1'b0;
         r_hit       <= 1'b0;
         r_cpu_ack   <= 1'b0;
         r_cpu_hit   <= 1'b0;
         r_cpu_rdata <= 32'd0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= 6'd0;
         r_mem_wdata <= 32'd0;
      end else begin
         // cpu_ack / cpu_hit are pulses; they default low every cycle.
         r_cpu_ack <= 1'b0;
         r_cpu_hit <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (cpu_req) begin
                  r_addr <= cpu_addr;
                  r_we   <= cpu_we;
                  r_hit  <= w_req_hit;
                  if (cpu_we) begin
                     // Write-through regardless of hit; no allocation.
                     r_state     <= ST_WTHRU;
                     r_mem_req   <= 1'b1;
                     r_mem_we    <= 1'b1;
                     r_mem_addr  <= cpu_addr;
                     r_mem_wdata <= cpu_wdata;
                  end else if (w_req_hit) begin
                     // Read hit completes from IDLE without a memory access.
                     r_cpu_ack   <= 1'b1;
                     r_cpu_hit   <= 1'b1;
                     r_cpu_rdata <= r_data[cpu_addr[3:0]];
                  end else begin
                     // Read miss: invalidate first so a partially refilled
                     // line can never look like a hit.
                     r_valid[w_req_line] <= 1'b0;
                     r_state    <= ST_REFILL;
                     r_cnt      <= 2'd0;
                     r_mem_req  <= 1'b1;
                     r_mem_we   <= 1'b0;
                     r_mem_addr <= {cpu_addr[5:2], 2'b00};
                  end
               end
            end

            ST_REFILL: begin
               if (w_mem_done) begin
                  r_cnt <= r_cnt + 2'd1;
                  if (r_cnt == 2'd3) begin
                     r_valid[r_addr[3:2]] <= 1'b1;
                     r_mem_req <= 1'b0;
                     r_state   <= ST_DONE;
                  end else begin
                     // Keep mem_req high and move straight to the next word.
                     r_mem_addr <= {r_addr[5:2], r_cnt + 2'd1};
                  end
               end
            end

            ST_WTHRU: begin
               if (w_mem_done) begin
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
                  r_state   <= ST_DONE;
               end
            end

            ST_DONE: begin
               r_cpu_ack <= 1'b1;
               // Reads report a miss; writes report hit-at-acceptance.
               r_cpu_hit <= r_we & r_hit;
               if (!r_we) begin
                  r_cpu_rdata <= r_data[r_addr[3:0]];
               end
               r_state <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign cpu_ack   = r_cpu_ack;
   assign cpu_hit   = r_cpu_hit;
   assign cpu_rdata = r_cpu_rdata;
   assign busy      = (r_state != ST_IDLE);
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_cache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_ctrl
// Directed plus randomized bench for cache_ctrl. A behavioural model keeps
// the cache contents as plain arrays (valid/tag/words per line) and the
// backing memory as a 64-word array; expected results, memory traffic and
// latencies are derived from the cache rules rather than from any FSM.
// -----------------------------------------------------------------------------
module tb_cache_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [5:0]  cpu_addr = 6'd0;
   logic [31:0] cpu_wdata = 32'd0;
   logic        cpu_ack;
   logic        cpu_hit;
   logic [31:0] cpu_rdata;
   logic        busy;
   logic        mem_req;
   logic        mem_we;
   logic [5:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'd0;

   cache_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ack   (cpu_ack),
      .cpu_hit   (cpu_hit),
      .cpu_rdata (cpu_rdata),
      .busy      (busy),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int txn_no = 0;

   // Backing memory and cache model
   logic [31:0] mem_model [64];
   logic        m_valid [4];
   logic [1:0]  m_tag   [4];
   logic [31:0] m_data  [4][4];
   logic [31:0] last_rdata = 32'd0;

   // Memory responder state; log entry = {we, addr, wdata(0 for reads)}
   logic [38:0] log_q[$];
   int  seen = 0;
   int  wait_sum = 0;
   int  cur_delay = 1;
   int  fixed_delay = 1;
   bit  rand_delay = 1'b0;
   bit  hold_ack = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_delay(input int d, input bit r);
      fixed_delay = d;
      rand_delay  = r;
      cur_delay   = r ? int'($urandom_range(0, 2)) : d;
   endtask

   // Memory: acks after cur_delay extra cycles of mem_req, one cycle per ack.
   // wait_sum accumulates the cycles mem_req was high up to each ack.
   initial begin
      forever begin
         @(negedge clk);
         if (mem_ack) seen = 0;
         mem_ack   = 1'b0;
         mem_rdata = $urandom;
         if (mem_req === 1'b1) begin
            seen++;
            if (!hold_ack && seen > cur_delay) begin
               mem_ack = 1'b1;
               if (mem_we) begin
                  mem_model[mem_addr] = mem_wdata;
                  log_q.push_back({1'b1, mem_addr, mem_wdata});
               end else begin
                  mem_rdata = mem_model[mem_addr];
                  log_q.push_back({1'b0, mem_addr, 32'h0});
               end
               wait_sum += seen;
               cur_delay = rand_delay ? int'($urandom_range(0, 2)) : fixed_delay;
            end
         end else begin
            seen = 0;
         end
      end
   end

   // One CPU transaction checked against the model. hold>0 keeps mem_ack low
   // for that many cycles while junk CPU requests are toggled.
   task automatic do_req(input bit we, input logic [5:0] a, input logic [31:0] wd, input int hold);
      logic [1:0]  line;
      logic        hit;
      logic        quick;
      logic        exp_hit;
      logic [31:0] exp_rdata;
      logic [38:0] exp_q[$];
      logic        got;
      int          lat;
      int          exp_lat;
      logic        busy_bad;
      logic        hit_bad;
      logic        hold_bad;
      logic [5:0]  hold_addr;
      logic        ack_hit;
      logic [31:0] ack_rdata;

      line  = a[3:2];
      hit   = m_valid[line] && (m_tag[line] == a[5:4]);
      quick = !we && hit;
      if (we) begin
         exp_hit   = hit;
         exp_rdata = last_rdata;
         exp_q.push_back({1'b1, a, wd});
         if (hit) m_data[line][a[1:0]] = wd;
      end else if (hit) begin
         exp_hit   = 1'b1;
         exp_rdata = m_data[line][a[1:0]];
      end else begin
         exp_hit = 1'b0;
         for (int k = 0; k < 4; k++) begin
            m_data[line][k] = mem_model[{a[5:2], 2'(k)}];
            exp_q.push_back({1'b0, a[5:2], 2'(k), 32'h0});
         end
         m_valid[line] = 1'b1;
         m_tag[line]   = a[5:4];
         exp_rdata     = m_data[line][a[1:0]];
      end

      log_q.delete();
      wait_sum = 0;
      if (hold > 0) hold_ack = 1'b1;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
      @(posedge clk); #1;
      cpu_req = 1'b0;

      got = 1'b0; lat = 0; busy_bad = 1'b0; hit_bad = 1'b0; hold_bad = 1'b0;
      hold_addr = 6'd0; ack_hit = 1'b0; ack_rdata = 32'd0;
      for (int k = 1; k <= 300 && !got; k++) begin
         @(negedge clk); #1;
         if (cpu_ack === 1'b1) begin
            got = 1'b1; lat = k; ack_hit = cpu_hit; ack_rdata = cpu_rdata;
            if (busy !== 1'b0) busy_bad = 1'b1;
         end else begin
            if (cpu_hit !== 1'b0) hit_bad = 1'b1;
            if (busy !== 1'b1) busy_bad = 1'b1;
         end
         if (hold > 0 && k <= hold) begin
            if (k == 1) hold_addr = mem_addr;
            if (mem_req !== 1'b1 || mem_addr !== hold_addr || mem_ack !== 1'b0) hold_bad = 1'b1;
            cpu_req   = k[0];
            cpu_we    = 1'($urandom);
            cpu_addr  = 6'($urandom);
            cpu_wdata = $urandom;
            if (k == hold) begin
               cpu_req  = 1'b0;
               hold_ack = 1'b0;
            end
         end
      end
      hold_ack = 1'b0;
      cpu_req  = 1'b0;

      exp_lat = quick ? 1 : wait_sum + 2;
      check("ack_seen", 64'(got), 64'(1'b1));
      check("latency", 64'(lat), 64'(exp_lat));
      check("cpu_hit", 64'(ack_hit), 64'(exp_hit));
      check("cpu_rdata", 64'(ack_rdata), 64'(exp_rdata));
      check("mem_count", 64'(log_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         check("mem_txn", (i < log_q.size()) ? 64'(log_q[i]) : 64'hFFFF_FFFF_FFFF_FFFF, 64'(exp_q[i]));
      end
      check("busy_profile", 64'(busy_bad), 64'(1'b0));
      check("hit_without_ack", 64'(hit_bad), 64'(1'b0));
      if (hold > 0) check("hold_stable", 64'(hold_bad), 64'(1'b0));

      @(negedge clk); #1;
      check("ack_pulse", 64'({cpu_ack, cpu_hit}), 64'(2'b00));

      last_rdata = exp_rdata;
      txn_no++;
      $display("txn %0d we=%0b addr=%02h wdata=%08h hit=%0b rdata=%08h lat=%0d exp_lat=%0d mem_ops=%0d",
               txn_no, we, a, wd, ack_hit, ack_rdata, lat, exp_lat, log_q.size());
   endtask

   initial begin : main
      int n;
      logic ack_in_abort;

      for (int i = 0; i < 64; i++) mem_model[i] = $urandom;
      for (int i = 0; i < 4; i++) begin
         mem_model[20 + i] = 32'hA0 + 32'(i);
         m_valid[i] = 1'b0;
         m_tag[i]   = 2'd0;
         for (int j = 0; j < 4; j++) m_data[i][j] = 32'd0;
      end

      // Reset state
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      check("rst_cpu_ack", 64'(cpu_ack), 64'(1'b0));
      check("rst_cpu_hit", 64'(cpu_hit), 64'(1'b0));
      check("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
      check("rst_mem_req", 64'(mem_req), 64'(1'b0));
      check("rst_mem_we", 64'(mem_we), 64'(1'b0));
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      check("rst_busy", 64'(busy), 64'(1'b0));
      rst = 1'b1;
      @(negedge clk); #1;

      // Directed: refill, hit, write-through hit, no-allocate miss, eviction
      set_delay(1, 1'b0);
      do_req(1'b0, 6'h15, 32'h0, 0);
      check("first_read_data", 64'(last_rdata), 64'hA1);
      do_req(1'b0, 6'h16, 32'h0, 0);
      check("reread_data", 64'(last_rdata), 64'hA2);
      do_req(1'b1, 6'h15, 32'hDEADBEEF, 0);
      do_req(1'b0, 6'h15, 32'h0, 0);
      check("write_hit_visible", 64'(last_rdata), 64'hDEADBEEF);
      do_req(1'b1, 6'h35, 32'h12345678, 0);
      do_req(1'b0, 6'h35, 32'h0, 0);
      do_req(1'b0, 6'h15, 32'h0, 0);

      // Back-to-back acks
      set_delay(0, 1'b0);
      do_req(1'b0, 6'h3A, 32'h0, 0);
      do_req(1'b1, 6'h3B, 32'hCAFEF00D, 0);
      do_req(1'b0, 6'h3B, 32'h0, 0);

      // Reset in the middle of a refill
      set_delay(1, 1'b0);
      log_q.delete();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'h08;
      @(posedge clk); #1;
      cpu_req = 1'b0;
      n = 0; ack_in_abort = 1'b0;
      for (int k = 0; k < 50 && n < 2; k++) begin
         @(negedge clk); #1;
         if (mem_req === 1'b1 && mem_ack === 1'b1) n++;
         if (cpu_ack === 1'b1) ack_in_abort = 1'b1;
      end
      hold_ack = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         if (cpu_ack === 1'b1) ack_in_abort = 1'b1;
      end
      check("abort_acks_seen", 64'(n), 64'd2);
      check("abort_mem_req", 64'(mem_req), 64'(1'b0));
      check("abort_busy", 64'(busy), 64'(1'b0));
      check("abort_no_cpu_ack", 64'(ack_in_abort), 64'(1'b0));
      rst = 1'b1;
      hold_ack = 1'b0;
      for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
      last_rdata = 32'd0;
      @(negedge clk); #1;
      do_req(1'b0, 6'h08, 32'h0, 0);

      // Long ack stall with ignored CPU requests
      do_req(1'b0, 6'h2C, 32'h0, 10);

      // Randomized traffic over two tags to mix hits and misses
      set_delay(0, 1'b1);
      for (int t = 0; t < 40; t++) begin
         do_req(($urandom_range(0, 2) == 0), 6'($urandom_range(0, 31)), $urandom, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "timeout");
   end

endmodule
